// File: rtl/gp_vertex_sequencer_if.sv
// Bundles the config bus, vertex/result handshakes and pipeline drive of gp_vertex_sequencer.
// master = environment (config host, vertex source, pipeline, result sink); slave = sequencer.
interface gp_vertex_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_dat;
  logic              cfg_err;

  logic              vtx_vld;
  logic              vtx_rdy;
  logic [DATA_W-1:0] vtx_x, vtx_y, vtx_z;

  logic [DATA_W-1:0] cam_ver_x, cam_ver_y, cam_ver_z, cam_dc;
  logic [DATA_W-1:0] cos_roll, cos_pitch, cos_yaw;
  logic [DATA_W-1:0] sen_roll, sen_pitch, sen_yaw;
  logic [DATA_W-1:0] scale_x, scale_y, scale_z;
  logic [DATA_W-1:0] transl_x, transl_y, transl_z;
  logic [DATA_W-1:0] vertex_x, vertex_y, vertex_z;

  logic [DATA_W-1:0] pipe_x, pipe_y;

  logic              out_vld;
  logic              out_rdy;
  logic [DATA_W-1:0] out_x, out_y;
  logic [15:0]       vtx_count;
  logic              busy;

  modport master (
    output cfg_we, cfg_addr, cfg_dat, vtx_vld, vtx_x, vtx_y, vtx_z,
           pipe_x, pipe_y, out_rdy,
    input  cfg_err, vtx_rdy,
           cam_ver_x, cam_ver_y, cam_ver_z, cam_dc,
           cos_roll, cos_pitch, cos_yaw, sen_roll, sen_pitch, sen_yaw,
           scale_x, scale_y, scale_z, transl_x, transl_y, transl_z,
           vertex_x, vertex_y, vertex_z, out_vld, out_x, out_y, vtx_count, busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_dat, vtx_vld, vtx_x, vtx_y, vtx_z,
           pipe_x, pipe_y, out_rdy,
    output cfg_err, vtx_rdy,
           cam_ver_x, cam_ver_y, cam_ver_z, cam_dc,
           cos_roll, cos_pitch, cos_yaw, sen_roll, sen_pitch, sen_yaw,
           scale_x, scale_y, scale_z, transl_x, transl_y, transl_z,
           vertex_x, vertex_y, vertex_z, out_vld, out_x, out_y, vtx_count, busy
  );
endinterface

// File: rtl/gp_vertex_sequencer.sv
// Parameter file + vertex sequencer in front of the combinational half-float transform pipeline.
// Latency: result valid PIPE_LAT edges after accept; PIPE_LAT+2 cycles per vertex.
// Backpressure: holds the result while out_rdy is low; no new vertex is accepted meanwhile.
module gp_vertex_sequencer #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int PIPE_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gp_vertex_sequencer_if.slave    sif
);
  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              vtx_rdy_q, busy_q, out_vld_q, cfg_err_q;
  logic [DATA_W-1:0] vertex_x_q, vertex_y_q, vertex_z_q, out_x_q, out_y_q;
  logic [15:0]       vtx_count_q;
  logic [DATA_W-1:0] prm_q [16];

  logic accept, cfg_ok;

  // Reset transform is the identity: cosines and scales at 1.0, everything else zero.
  function automatic logic [DATA_W-1:0] prm_rst(input int idx);
    if ((idx >= 4 && idx <= 6) || (idx >= 10 && idx <= 12))
      return DATA_W'(16'h3C00);
    return '0;
  endfunction

  assign accept = vtx_rdy_q && sif.vtx_vld;
  assign cfg_ok = sif.cfg_we && (state_q == IDLE) && (sif.cfg_addr[ADDR_W-1:4] == '0) && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) prm_q[i] <= prm_rst(i);
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= sif.cfg_we && !cfg_ok;
      if (cfg_ok) prm_q[sif.cfg_addr[3:0]] <= sif.cfg_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vtx_rdy_q   <= 1'b1;
      busy_q      <= 1'b0;
      out_vld_q   <= 1'b0;
      vertex_x_q  <= '0;
      vertex_y_q  <= '0;
      vertex_z_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      vtx_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          vertex_x_q <= sif.vtx_x;
          vertex_y_q <= sif.vtx_y;
          vertex_z_q <= sif.vtx_z;
          cnt_q      <= 4'(PIPE_LAT - 1);
          vtx_rdy_q  <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= WAIT;
        end
        WAIT: if (cnt_q == '0) begin
          out_x_q   <= sif.pipe_x;
          out_y_q   <= sif.pipe_y;
          out_vld_q <= 1'b1;
          state_q   <= OUT;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        OUT: if (sif.out_rdy) begin
          out_vld_q   <= 1'b0;
          vtx_count_q <= vtx_count_q + 16'd1;
          vtx_rdy_q   <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sif.cfg_err   = cfg_err_q;
  assign sif.vtx_rdy   = vtx_rdy_q;
  assign sif.busy      = busy_q;
  assign sif.out_vld   = out_vld_q;
  assign sif.out_x     = out_x_q;
  assign sif.out_y     = out_y_q;
  assign sif.vtx_count = vtx_count_q;
  assign sif.vertex_x  = vertex_x_q;
  assign sif.vertex_y  = vertex_y_q;
  assign sif.vertex_z  = vertex_z_q;

  assign sif.cam_ver_x = prm_q[0];
  assign sif.cam_ver_y = prm_q[1];
  assign sif.cam_ver_z = prm_q[2];
  assign sif.cam_dc    = prm_q[3];
  assign sif.cos_roll  = prm_q[4];
  assign sif.cos_pitch = prm_q[5];
  assign sif.cos_yaw   = prm_q[6];
  assign sif.sen_roll  = prm_q[7];
  assign sif.sen_pitch = prm_q[8];
  assign sif.sen_yaw   = prm_q[9];
  assign sif.scale_x   = prm_q[10];
  assign sif.scale_y   = prm_q[11];
  assign sif.scale_z   = prm_q[12];
  assign sif.transl_x  = prm_q[13];
  assign sif.transl_y  = prm_q[14];
  assign sif.transl_z  = prm_q[15];
endmodule

// File: tb/tb_gp_vertex_sequencer.sv
// Directed bench for gp_vertex_sequencer; the pipeline stand-in mixes vertex and parameters by XOR.
module tb_gp_vertex_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchecks = 0;
  int   nerr = 0;
  int   cyc;

  gp_vertex_sequencer_if #(.DATA_W(16), .ADDR_W(5)) sif ();

  gp_vertex_sequencer #(.DATA_W(16), .ADDR_W(5), .PIPE_LAT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  always #5 clk = ~clk;

  // Pipeline stand-in: result depends on both the latched vertex and the parameter file.
  assign sif.pipe_x = sif.vertex_x ^ sif.transl_x;
  assign sif.pipe_y = sif.vertex_y ^ sif.cam_dc;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [4:0] addr, input logic [15:0] dat);
    @(negedge clk);
    sif.cfg_we = 1'b1; sif.cfg_addr = addr; sif.cfg_dat = dat;
    @(negedge clk);
    sif.cfg_we = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.cfg_we = 0; sif.cfg_addr = '0; sif.cfg_dat = '0;
    sif.vtx_vld = 0; sif.vtx_x = '0; sif.vtx_y = '0; sif.vtx_z = '0;
    sif.out_rdy = 0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cos_pitch", sif.cos_pitch, 16'h3C00);
    check("rst_scale_y",   sif.scale_y,   16'h3C00);
    check("rst_transl_x",  sif.transl_x,  16'h0000);
    check("rst_vtx_rdy",   16'(sif.vtx_rdy), 16'd1);
    check("rst_out_vld",   16'(sif.out_vld), 16'd0);
    check("rst_vtx_count", sif.vtx_count, 16'h0000);
    check("rst_busy",      16'(sif.busy), 16'd0);
    rst_n = 1'b1;

    // Config writes in IDLE, including the top valid address
    cfg_write(5'd13, 16'hC799);
    check("cfg_transl_x", sif.transl_x, 16'hC799);
    check("cfg_err_ok",   16'(sif.cfg_err), 16'd0);
    cfg_write(5'd15, 16'h4E40);
    check("cfg_transl_z", sif.transl_z, 16'h4E40);
    check("cfg_transl_y", sif.transl_y, 16'h0000);
    cfg_write(5'd3, 16'h4700);
    check("cfg_cam_dc", sif.cam_dc, 16'h4700);
    cfg_write(5'd20, 16'h1234);
    check("bad_addr_err",      16'(sif.cfg_err), 16'd1);
    check("bad_addr_cos_roll", sif.cos_roll, 16'h3C00);
    @(negedge clk);
    check("bad_addr_err_clr", 16'(sif.cfg_err), 16'd0);

    // Vertex accept at edge N, busy write during WAIT, result at N+4
    sif.vtx_vld = 1; sif.vtx_x = 16'hCD40; sif.vtx_y = 16'h4780; sif.vtx_z = 16'hC500;
    @(negedge clk);
    check("acc_vertex_x", sif.vertex_x, 16'hCD40);
    check("acc_vertex_y", sif.vertex_y, 16'h4780);
    check("acc_vertex_z", sif.vertex_z, 16'hC500);
    check("acc_vtx_rdy",  16'(sif.vtx_rdy), 16'd0);
    check("acc_busy",     16'(sif.busy), 16'd1);
    sif.vtx_x = 16'h1111;
    sif.cfg_we = 1; sif.cfg_addr = 5'd4; sif.cfg_dat = 16'h3800;
    @(negedge clk);
    sif.cfg_we = 0;
    check("busy_cfg_err", 16'(sif.cfg_err), 16'd1);
    check("lat_n1_vld",   16'(sif.out_vld), 16'd0);
    @(negedge clk);
    check("busy_cos_roll",    sif.cos_roll, 16'h3C00);
    check("busy_cfg_err_clr", 16'(sif.cfg_err), 16'd0);
    check("lat_n2_vld",       16'(sif.out_vld), 16'd0);
    @(negedge clk);
    check("lat_n3_vld", 16'(sif.out_vld), 16'd0);
    @(negedge clk);
    check("lat_n4_vld",      16'(sif.out_vld), 16'd1);
    check("res_out_x",       sif.out_x, 16'h0AD9);
    check("res_out_y",       sif.out_y, 16'h0080);
    check("ignored_vertex_x", sif.vertex_x, 16'hCD40);
    sif.vtx_vld = 0;

    // Backpressure: result held, nothing accepted
    for (int i = 0; i < 10; i++) begin
      sif.vtx_vld = 1; sif.vtx_x = 16'h2222;
      @(negedge clk);
      check("bp_out_vld", 16'(sif.out_vld), 16'd1);
      check("bp_out_x",   sif.out_x, 16'h0AD9);
      check("bp_vtx_rdy", 16'(sif.vtx_rdy), 16'd0);
    end
    sif.vtx_vld = 0;
    check("bp_out_y",    sif.out_y, 16'h0080);
    check("bp_vertex_x", sif.vertex_x, 16'hCD40);
    sif.out_rdy = 1;
    @(negedge clk);
    check("dlv_out_vld",   16'(sif.out_vld), 16'd0);
    check("dlv_vtx_count", sif.vtx_count, 16'd1);
    check("dlv_vtx_rdy",   16'(sif.vtx_rdy), 16'd1);
    check("dlv_busy",      16'(sif.busy), 16'd0);

    // Throughput with out_rdy high: two vertices in 2*(PIPE_LAT+2) cycles
    sif.vtx_vld = 1; sif.vtx_x = 16'h0101; sif.vtx_y = 16'h0202; sif.vtx_z = 16'h0303;
    cyc = 0;
    while (sif.vtx_count != 16'd3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    sif.vtx_vld = 0;
    check("thru_cycles", 16'(cyc), 16'd12);

    // Async reset in WAIT
    @(negedge clk);
    sif.vtx_vld = 1; sif.vtx_x = 16'h5555;
    @(negedge clk);
    sif.vtx_vld = 0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",      16'(sif.busy), 16'd0);
    check("arst_vtx_rdy",   16'(sif.vtx_rdy), 16'd1);
    check("arst_out_vld",   16'(sif.out_vld), 16'd0);
    check("arst_vtx_count", sif.vtx_count, 16'd0);
    check("arst_transl_x",  sif.transl_x, 16'h0000);
    check("arst_cam_dc",    sif.cam_dc, 16'h0000);
    check("arst_vertex_x",  sif.vertex_x, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Count wrap from 0xFFFF
    @(negedge clk);
    force dut.vtx_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.vtx_count_q;
    sif.vtx_vld = 1; sif.vtx_x = 16'h0001;
    @(negedge clk);
    sif.vtx_vld = 0;
    repeat (4) @(negedge clk);
    check("wrap_pre_count", sif.vtx_count, 16'hFFFF);
    check("wrap_out_vld",   16'(sif.out_vld), 16'd1);
    @(negedge clk);
    check("wrap_count", sif.vtx_count, 16'h0000);
    check("wrap_busy",  16'(sif.busy), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
